// File: rtl/tcycle_scheduler_pkg.sv
// Shared types and constants for the T-cycle timebase and its clients.
// Slot indices name the owner of each phase within a T-cycle.
package fpgaboy_pkg;

  typedef enum logic [1:0] {
    SCHED_RUN      = 2'd0,
    SCHED_HALTED   = 2'd1,
    SCHED_STEPPING = 2'd2
  } sched_state_t;

  localparam int TCYCLES_PER_MCYCLE = 4;

  localparam int SLOT_CPU    = 0;
  localparam int SLOT_PPU    = 1;
  localparam int SLOT_MEM    = 2;
  localparam int SLOT_SETTLE = 3;

  // Counter width that stays legal even for a modulus of 1.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/tcycle_scheduler_evtcounter.sv
// Modulo-MAX_COUNT event counter: advances on evt_in, flags the wrapping event.
// wrap_out is combinational so the parent can act in the same clk as the wrap.
module EvtCounter
  import fpgaboy_pkg::*;
#(
  parameter  int MAX_COUNT = 24,
  localparam int CNT_W     = cnt_width(MAX_COUNT)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             evt_in,
  output logic [CNT_W-1:0] count_out,
  output logic             wrap_out
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign wrap_out  = evt_in && (count_q == CNT_W'(MAX_COUNT - 1));
  assign count_out = count_q;

  always_comb begin
    count_d = count_q;
    if (wrap_out) begin
      count_d = '0;
    end else if (evt_in) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tcycle_scheduler.sv
// T-cycle/M-cycle timebase with per-slot strobes and run/halt/single-step control.
// Halting and step completion are only decided on the last clk of a T-cycle.
module tcycle_scheduler
  import fpgaboy_pkg::*;
#(
  parameter  int CLK_PER_TCYCLE = 24,
  parameter  int NUM_SLOTS      = 4,
  parameter  bit START_RUNNING  = 1'b1,
  localparam int CNT_W          = cnt_width(CLK_PER_TCYCLE)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 run_in,
  input  logic                 step_in,
  input  logic                 step_mode_in,
  output logic                 tclk_out,
  output logic                 mclk_out,
  output logic [NUM_SLOTS-1:0] slot_active_out,
  output logic [NUM_SLOTS-1:0] slot_start_out,
  output logic [CNT_W-1:0]     cnt_out,
  output logic [1:0]           mphase_out,
  output logic                 halted_out
);

  localparam int         SLOT_CLKS   = CLK_PER_TCYCLE / NUM_SLOTS;
  localparam logic [1:0] LAST_MPHASE = 2'(TCYCLES_PER_MCYCLE - 1);

  if ((CLK_PER_TCYCLE % NUM_SLOTS) != 0 || CLK_PER_TCYCLE < NUM_SLOTS) begin : g_bad_params
    $error("CLK_PER_TCYCLE must be a non-zero multiple of NUM_SLOTS");
  end

  sched_state_t     state_q, state_d;
  logic             step_m_q, step_m_d;
  logic [1:0]       mphase_q, mphase_d;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             core_active;
  logic             out_active;

  assign core_active = (state_q != SCHED_HALTED);

  EvtCounter #(
    .MAX_COUNT(CLK_PER_TCYCLE)
  ) u_evt_counter (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .evt_in    (core_active),
    .count_out (cnt),
    .wrap_out  (wrap)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= START_RUNNING ? SCHED_RUN : SCHED_HALTED;
      step_m_q <= 1'b0;
      mphase_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      step_m_q <= step_m_d;
      mphase_q <= mphase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_m_d = step_m_q;
    mphase_d = wrap ? (mphase_q + 2'd1) : mphase_q;
    case (state_q)
      SCHED_RUN: begin
        if (wrap && !run_in) begin
          state_d = SCHED_HALTED;
        end
      end
      SCHED_HALTED: begin
        if (run_in) begin
          state_d = SCHED_RUN;
        end else if (step_in) begin
          state_d  = SCHED_STEPPING;
          step_m_d = step_mode_in;
        end
      end
      SCHED_STEPPING: begin
        // Run request wins over any remaining part of the step.
        if (wrap) begin
          if (run_in) begin
            state_d = SCHED_RUN;
          end else if (!step_m_q || (mphase_q == LAST_MPHASE)) begin
            state_d = SCHED_HALTED;
          end
        end
      end
      default: state_d = SCHED_HALTED;
    endcase
  end

  // Strobes are forced low while reset is held so no client fires in the reset cycle.
  always_comb begin
    out_active = core_active && !rst_in;
    tclk_out   = out_active && (cnt == '0);
    mclk_out   = tclk_out && (mphase_q == 2'd0);
    halted_out = (state_q == SCHED_HALTED);
    cnt_out    = cnt;
    mphase_out = mphase_q;
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    localparam int LO = gi * SLOT_CLKS;
    localparam int HI = LO + SLOT_CLKS;
    assign slot_active_out[gi] = out_active && (int'(cnt) >= LO) && (int'(cnt) < HI);
    assign slot_start_out[gi]  = out_active && (int'(cnt) == LO);
  end

endmodule

// File: tb/tb_tcycle_scheduler.sv
// Directed bench: a scoreboard of expected T-cycles (mphase, mclk) checked on every tclk,
// plus direct checks of slot decode, halt/step behaviour and reset on a second, halted-start instance.
module tb_tcycle_scheduler;

  localparam int CPT = 8;
  localparam int NS  = 4;

  typedef struct {
    logic [1:0] mphase;
    logic       mclk;
  } exp_t;

  exp_t scb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, run = 1'b1, step = 1'b0, smode = 1'b0;
  logic          tclk, mclk, halted;
  logic [NS-1:0] sact, sst;
  logic [2:0]    cnt;
  logic [1:0]    mph;

  logic          rst_h = 1'b1, run_h = 1'b0, step_h = 1'b0, smode_h = 1'b0;
  logic          tclk_h, mclk_h, halted_h;
  logic [NS-1:0] sact_h, sst_h;
  logic [2:0]    cnt_h;
  logic [1:0]    mph_h;

  tcycle_scheduler #(.CLK_PER_TCYCLE(CPT), .NUM_SLOTS(NS), .START_RUNNING(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .run_in(run), .step_in(step), .step_mode_in(smode),
    .tclk_out(tclk), .mclk_out(mclk), .slot_active_out(sact), .slot_start_out(sst),
    .cnt_out(cnt), .mphase_out(mph), .halted_out(halted)
  );

  tcycle_scheduler #(.CLK_PER_TCYCLE(CPT), .NUM_SLOTS(NS), .START_RUNNING(1'b0)) dut_h (
    .clk_in(clk), .rst_in(rst_h), .run_in(run_h), .step_in(step_h), .step_mode_in(smode_h),
    .tclk_out(tclk_h), .mclk_out(mclk_h), .slot_active_out(sact_h), .slot_start_out(sst_h),
    .cnt_out(cnt_h), .mphase_out(mph_h), .halted_out(halted_h)
  );

  logic [NS-1:0] act_tbl [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                 4'b0100, 4'b0100, 4'b1000, 4'b1000};
  logic [NS-1:0] sst_tbl [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                 4'b0100, 4'b0000, 4'b1000, 4'b0000};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_t(input logic [1:0] mp, input logic mc);
    exp_t e;
    e.mphase = mp;
    e.mclk   = mc;
    scb_q.push_back(e);
  endtask

  // Monitor: every executed T-cycle must match the next expected record.
  always @(negedge clk) begin
    exp_t e;
    if (tclk) begin
      if (scb_q.size() == 0) begin
        check("tclk_unexpected", int'(tclk), 0);
      end else begin
        e = scb_q.pop_front();
        check("tclk_mphase", int'(mph), int'(e.mphase));
        check("tclk_mclk", int'(mclk), int'(e.mclk));
      end
    end else if (mclk) begin
      check("mclk_without_tclk", int'(mclk), int'(tclk));
    end
  end

  task automatic do_step(input logic mode, input int exp_act, input int exp_mph, input string tag);
    int act = 0;
    check({tag, "_pre_halted"}, int'(halted), 1);
    step  = 1'b1;
    smode = mode;
    tick(1);
    step  = 1'b0;
    smode = ~mode;
    for (int k = 0; k < exp_act + 6; k++) begin
      @(negedge clk);
      if (sact != '0) act++;
      tick(1);
    end
    check({tag, "_active_clks"}, act, exp_act);
    check({tag, "_halted"}, int'(halted), 1);
    check({tag, "_mphase"}, int'(mph), exp_mph);
    check({tag, "_scb_empty"}, scb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset cycle: strobes gated off even though state is RUN.
    tick(2);
    @(negedge clk);
    check("rst_tclk", int'(tclk), 0);
    check("rst_slot_active", int'(sact), 0);
    check("rst_slot_start", int'(sst), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_mphase", int'(mph), 0);
    check("rst_halted", int'(halted), 0);

    // Test 1/2 T-cycles: 8 free-running plus the one that completes after run drops.
    for (int i = 0; i < 9; i++) push_t(2'(i % 4), (i % 4) == 0);
    tick(1);
    rst   = 1'b0;
    rst_h = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("h_reset_halted", int'(halted_h), 1);
        check("h_reset_slot_active", int'(sact_h), 0);
        check("h_reset_tclk", int'(tclk_h), 0);
      end
      check($sformatf("run_slot_active_c%0d", i), int'(sact), int'(act_tbl[i % 8]));
      check($sformatf("run_slot_start_c%0d", i), int'(sst), int'(sst_tbl[i % 8]));
      check($sformatf("run_cnt_c%0d", i), int'(cnt), i % 8);
      tick(1);
    end

    // Test 2: drop run at cnt=3 of T-cycle 8; slots 2 and 3 must still run.
    tick(51);
    run = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("halt_tail_slot_c%0d", 4 + i), int'(sact), int'(act_tbl[4 + i]));
      check($sformatf("halt_tail_halted_c%0d", 4 + i), int'(halted), 0);
      tick(1);
    end
    @(negedge clk);
    check("halt_halted", int'(halted), 1);
    check("halt_slot_active", int'(sact), 0);
    check("halt_cnt", int'(cnt), 0);
    check("halt_mphase", int'(mph), 1);
    tick(10);
    check("halt_scb_empty", scb_q.size(), 0);

    // Test 4: M-step from mphase 1, then from 0; test 3: T-step from 0.
    push_t(2'd1, 1'b0); push_t(2'd2, 1'b0); push_t(2'd3, 1'b0);
    do_step(1'b1, 24, 0, "mstep_from1");
    push_t(2'd0, 1'b1); push_t(2'd1, 1'b0); push_t(2'd2, 1'b0); push_t(2'd3, 1'b0);
    do_step(1'b1, 32, 0, "mstep_from0");
    push_t(2'd0, 1'b1);
    do_step(1'b0, 8, 1, "tstep_from0");

    // Test 5: run+step together resumes running; a step pulse while running is ignored.
    push_t(2'd1, 1'b0); push_t(2'd2, 1'b0); push_t(2'd3, 1'b0);
    run  = 1'b1;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    @(negedge clk);
    check("runstep_halted", int'(halted), 0);
    tick(10);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(9);
    run = 1'b0;
    tick(8);
    @(negedge clk);
    check("runstep_end_halted", int'(halted), 1);
    check("runstep_end_mphase", int'(mph), 0);
    check("runstep_scb_empty", scb_q.size(), 0);

    // Test 6: reset at cnt=5 of a T-step on the halted-start instance.
    step_h  = 1'b1;
    smode_h = 1'b0;
    tick(1);
    step_h = 1'b0;
    tick(5);
    @(negedge clk);
    check("h_step_cnt", int'(cnt_h), 5);
    check("h_step_halted", int'(halted_h), 0);
    rst_h = 1'b1;
    tick(1);
    @(negedge clk);
    check("h_rst_cnt", int'(cnt_h), 0);
    check("h_rst_mphase", int'(mph_h), 0);
    check("h_rst_tclk", int'(tclk_h), 0);
    check("h_rst_mclk", int'(mclk_h), 0);
    check("h_rst_slot_active", int'(sact_h), 0);
    check("h_rst_slot_start", int'(sst_h), 0);
    check("h_rst_halted", int'(halted_h), 1);
    rst_h = 1'b0;
    tick(3);
    @(negedge clk);
    check("h_post_halted", int'(halted_h), 1);
    check("h_post_slot_active", int'(sact_h), 0);
    check("h_post_cnt", int'(cnt_h), 0);
    check("final_scb_empty", scb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
